// File: rtl/coin_pulse_pkg.sv
// rtl/coin_pulse_pkg.sv - shared types and helpers for the coin pulse queue
package coin_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coin_pulse_if.sv
// rtl/coin_pulse_if.sv - timing, request and pulse bundle between host and coin pulse queue
interface coin_pulse_if #(
  parameter int NUM_CH = 2
);
  logic              ce;
  logic              pause;
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] pulse_out;
  logic [NUM_CH-1:0] busy;

  modport master (output ce, pause, raw_in, input pulse_out, busy);
  modport slave  (input ce, pause, raw_in, output pulse_out, busy);
endinterface

// File: rtl/coin_pulse_ch.sv
// rtl/coin_pulse_ch.sv - one channel: synchronizer, debouncer, pending queue, pulse FSM
module coin_pulse_ch
  import coin_pulse_pkg::*;
#(
  parameter int DEB_TICKS   = 4,
  parameter int PULSE_TICKS = 6,
  parameter int GAP_TICKS   = 6,
  parameter int MAX_PEND    = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic pause,
  input  logic lockout,
  input  logic raw_in,
  output logic pulse_out,
  output logic busy
);

  localparam int DCW = $clog2(DEB_TICKS + 1);
  localparam int PEW = $clog2(MAX_PEND + 1);
  localparam int PCW = $clog2(max2(PULSE_TICKS, GAP_TICKS) + 1);

  logic [1:0]     sync_q;
  logic           s;
  logic           stable;
  logic           stable_d;
  logic [DCW-1:0] dcnt;
  logic [PEW-1:0] pend;
  logic [PCW-1:0] pcnt;
  coin_state_t    state;
  logic           press;
  logic           accept;
  logic           start;

  assign s      = sync_q[1];
  assign press  = stable & ~stable_d;
  assign accept = press & ~lockout;
  assign start  = (state == IDLE) && (pend != '0) && !pause;
  assign busy   = (pend != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      dcnt     <= '0;
      pend     <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw_in};
      stable_d <= stable;
      if (s == stable) begin
        dcnt <= '0;
      end else if (ce) begin
        if (dcnt == DCW'(DEB_TICKS - 1)) begin
          stable <= s;
          dcnt   <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
      // simultaneous accept and start cancel out, so a full queue stays full
      if (accept && !start) begin
        if (pend != PEW'(MAX_PEND)) pend <= pend + 1'b1;
      end else if (start && !accept) begin
        pend <= pend - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pcnt      <= '0;
      pulse_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PULSE;
            pcnt      <= '0;
            pulse_out <= 1'b1;
          end
        end
        PULSE: begin
          if (ce && !pause) begin
            if (pcnt == PCW'(PULSE_TICKS - 1)) begin
              state     <= GAP;
              pcnt      <= '0;
              pulse_out <= 1'b0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (ce && !pause) begin
            if (pcnt == PCW'(GAP_TICKS - 1)) begin
              state <= IDLE;
              pcnt  <= '0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          pcnt      <= '0;
          pulse_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/coin_pulse_queue.sv
// rtl/coin_pulse_queue.sv - debounced, queued coin/service pulse generator (lockout input with COIN_LOCKOUT_EN)
module coin_pulse_queue
  import coin_pulse_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DEB_TICKS   = 4,
  parameter int PULSE_TICKS = 6,
  parameter int GAP_TICKS   = 6,
  parameter int MAX_PEND    = 7
) (
  input  logic         clk,
  input  logic         reset,
`ifdef COIN_LOCKOUT_EN
  input  logic         lockout,
`endif
  coin_pulse_if.slave  bus
);

  logic              lockout_i;
  logic [NUM_CH-1:0] pulse_v;
  logic [NUM_CH-1:0] busy_v;

`ifdef COIN_LOCKOUT_EN
  assign lockout_i = lockout;
`else
  assign lockout_i = 1'b0;
`endif

  assign bus.pulse_out = pulse_v;
  assign bus.busy      = busy_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    coin_pulse_ch #(
      .DEB_TICKS  (DEB_TICKS),
      .PULSE_TICKS(PULSE_TICKS),
      .GAP_TICKS  (GAP_TICKS),
      .MAX_PEND   (MAX_PEND)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .ce       (bus.ce),
      .pause    (bus.pause),
      .lockout  (lockout_i),
      .raw_in   (bus.raw_in[i]),
      .pulse_out(pulse_v[i]),
      .busy     (busy_v[i])
    );
  end

endmodule

// File: tb/tb_coin_pulse_queue.sv
// tb/tb_coin_pulse_queue.sv - directed bench for coin_pulse_queue (lockout case with COIN_LOCKOUT_EN)
module tb_coin_pulse_queue;

  logic clk;
  logic reset;
`ifdef COIN_LOCKOUT_EN
  logic lockout;
`endif

  coin_pulse_if #(.NUM_CH(2)) bus ();

  coin_pulse_queue dut (
    .clk    (clk),
    .reset  (reset),
`ifdef COIN_LOCKOUT_EN
    .lockout(lockout),
`endif
    .bus    (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // pulse observer state, sampled on the falling edge
  int pc0, pc1, ht, hclk, last_ht, last_hclk, min_ht, max_ht, min_gap, gt;
  bit prev0, prev1, seen_pulse, busy_seen, mon_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ce every 4th clk, updated 1 time unit after the edge
  int ce_div = 0;
  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce_div = (ce_div + 1) % 4;
      bus.ce = (ce_div == 0);
    end
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      pc0 = 0; pc1 = 0; ht = 0; hclk = 0; last_ht = 0; last_hclk = 0;
      min_ht = 999; max_ht = 0; min_gap = 999; gt = 0;
      seen_pulse = 0; busy_seen = 0;
    end else begin
      if (bus.busy != 0) busy_seen = 1;
      if (bus.pulse_out[1] && !prev1) pc1++;
      if (bus.pulse_out[0]) begin
        if (!prev0) begin
          pc0++;
          if (seen_pulse && gt < min_gap) min_gap = gt;
          ht = 0;
          hclk = 0;
        end
        hclk++;
        if (bus.ce && !bus.pause) ht++;
      end else begin
        if (prev0) begin
          last_ht = ht;
          last_hclk = hclk;
          if (ht < min_ht) min_ht = ht;
          if (ht > max_ht) max_ht = ht;
          seen_pulse = 1;
          gt = 0;
        end
        if (bus.ce && !bus.pause) gt++;
      end
    end
    prev0 = bus.pulse_out[0];
    prev1 = bus.pulse_out[1];
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // stimulus acts 2 time units after the edge, after ce has settled
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    step(1);
  endtask

  task automatic press(input int ch, input int hi, input int lo);
    bus.raw_in[ch] = 1'b1;
    step(hi);
    bus.raw_in[ch] = 1'b0;
    step(lo);
  endtask

  task automatic wait_rise0(input string tag);
    int n = 0;
    while (!bus.pulse_out[0] && n < 400) begin
      step(1);
      n++;
    end
    check(tag, int'(bus.pulse_out[0]), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus.busy != 0 || bus.pulse_out != 0) && n < 3000) begin
      step(1);
      n++;
    end
    check(tag, int'(bus.busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  all_high;
    reset      = 1'b1;
    bus.pause  = 1'b0;
    bus.raw_in = '0;
    mon_clr    = 1'b1;
`ifdef COIN_LOCKOUT_EN
    lockout    = 1'b0;
`endif
    step(4);
    reset = 1'b0;
    mon_clear();
    check("reset_pulse", int'(bus.pulse_out), 0);
    check("reset_busy", int'(bus.busy), 0);

    // single clean press
    press(0, 40, 40);
    wait_idle("t1_idle");
    check("t1_pulses", pc0, 1);
    check("t1_ticks", last_ht, 6);
    check("t1_width_clk", int'(last_hclk >= 21 && last_hclk <= 24), 1);
    check("t1_ch1_quiet", pc1, 0);

    // 3-tick glitch is rejected
    mon_clear();
    press(0, 12, 60);
    check("t2_pulses", pc0, 0);
    check("t2_busy_seen", int'(busy_seen), 0);

    // queue saturation: pulse frozen by pause while 9 more presses arrive
    mon_clear();
    bus.raw_in[0] = 1'b1;
    wait_rise0("t3_rise");
    bus.pause = 1'b1;
    step(40);
    bus.raw_in[0] = 1'b0;
    step(40);
    for (int i = 0; i < 9; i++) press(0, 40, 40);
    bus.pause = 1'b0;
    wait_idle("t3_idle");
    check("t3_pulses", pc0, 8);
    check("t3_min_ticks", min_ht, 6);
    check("t3_max_ticks", max_ht, 6);
    check("t3_min_gap_ge6", int'(min_gap >= 6), 1);

    // pause 3 ticks into a pulse for 50 ticks
    mon_clear();
    bus.raw_in[0] = 1'b1;
    wait_rise0("t4_rise");
    bus.raw_in[0] = 1'b0;
    n = 0;
    while (n < 3) begin
      if (bus.ce) n++;
      step(1);
    end
    bus.pause = 1'b1;
    all_high = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (!bus.pulse_out[0]) all_high = 1'b0;
    end
    bus.pause = 1'b0;
    wait_idle("t4_idle");
    check("t4_held_high", int'(all_high), 1);
    check("t4_ticks", last_ht, 6);
    check("t4_pulses", pc0, 1);

    // reset mid-pulse with two presses queued
    mon_clear();
    bus.raw_in[0] = 1'b1;
    wait_rise0("t5_rise");
    bus.raw_in[0] = 1'b0;
    bus.pause = 1'b1;
    step(40);
    press(0, 40, 40);
    press(0, 40, 40);
    check("t5_busy_before", int'(bus.busy[0]), 1);
    reset = 1'b1;
    step(1);
    check("t5_pulse_after", int'(bus.pulse_out[0]), 0);
    check("t5_busy_after", int'(bus.busy), 0);
    reset = 1'b0;
    bus.pause = 1'b0;
    mon_clear();
    step(200);
    check("t5_no_more", pc0, 0);

    // ch1 held high across reset release yields one pulse
    mon_clear();
    bus.raw_in[1] = 1'b1;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(150);
    bus.raw_in[1] = 1'b0;
    wait_idle("t5b_idle");
    check("t5b_ch1_pulses", pc1, 1);
    check("t5b_ch0_quiet", pc0, 0);

`ifdef COIN_LOCKOUT_EN
    mon_clear();
    lockout = 1'b1;
    press(0, 40, 40);
    step(100);
    check("t6_locked", pc0, 0);
    lockout = 1'b0;
    bus.pause = 1'b1;
    press(0, 40, 40);
    lockout = 1'b1;
    bus.pause = 1'b0;
    wait_idle("t6_idle");
    check("t6_queued", pc0, 1);
    lockout = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
